// File: rtl/s2a_burst_writer.sv
// Purpose : buffer a valid/ready sample stream in a FWFT FIFO and write it out as
//           fixed-length AXI INCR bursts into a circular buffer of isize bursts at ibase.
// Latency : AW goes valid the cycle after the FIFO level reaches BURST_LEN; W beats follow the AW handshake.
// Backpr. : s_ready drops when the FIFO is full or a sync is pending. Data is popped only on wvalid&wready.
//           Only one burst is outstanding: the next AW waits for the previous B.
// Ports   : AXI_clk/rst      clock, synchronous active-high reset
//           sync             restart request; it clears the FIFO and counters once the FSM is idle
//           s_data/valid/ready   input sample stream
//           ibase/isize      buffer base byte address and buffer size in bursts (isize 0 acts as 1)
//           iacnt/ibcnt      next burst index and completed buffer wraps
//           ierr_cnt         count of bursts with a non-OKAY BRESP (saturating)
//           AXI_aw*/w*/b*    AXI write address, data and response channels
module s2a_burst_writer #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16,
  parameter int FIFO_AW   = 5,
  parameter int SIZE_W    = 18
) (
  input  logic                AXI_clk,
  input  logic                rst,
  input  logic                sync,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [31:0]         ibase,
  input  logic [SIZE_W-1:0]   isize,
  output logic [SIZE_W-1:0]   iacnt,
  output logic [31:0]         ibcnt,
  output logic [15:0]         ierr_cnt,
  output logic [31:0]         AXI_awaddr,
  output logic [7:0]          AXI_awlen,
  output logic [2:0]          AXI_awsize,
  output logic [1:0]          AXI_awburst,
  output logic                AXI_awvalid,
  input  logic                AXI_awready,
  output logic [DATA_W-1:0]   AXI_wdata,
  output logic [DATA_W/8-1:0] AXI_wstrb,
  output logic                AXI_wvalid,
  input  logic                AXI_wready,
  output logic                AXI_wlast,
  input  logic                AXI_bvalid,
  input  logic [1:0]          AXI_bresp,
  output logic                AXI_bready
);

  localparam int BB_LG  = $clog2(BURST_LEN * DATA_W / 8);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam logic [31:0]        ALIGN_MASK = ~((32'd1 << BB_LG) - 32'd1);
  localparam logic [FIFO_AW:0]   FULL_LVL   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   BURST_LVL  = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    level_q, level_d;
  logic                sync_pend_q, sync_pend_d;
  logic [SIZE_W-1:0]   iacnt_q, iacnt_d;
  logic [31:0]         ibcnt_q, ibcnt_d;
  logic [15:0]         err_q, err_d;
  logic [31:0]         awaddr_q, awaddr_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic                full, push, pop, clr;
  logic [SIZE_W-1:0]   isize_eff;

  // rst gates s_ready directly so that the stream is refused during the reset cycle itself.
  assign full      = (level_q == FULL_LVL);
  assign s_ready   = !rst && !full && !sync_pend_q;
  assign push      = s_valid && s_ready;
  assign pop       = wvalid_q && AXI_wready;
  // A pending restart takes effect only between bursts, so any in-flight burst completes first.
  assign clr       = sync_pend_q && (state_q == ST_IDLE);
  assign isize_eff = (isize == '0) ? SIZE_W'(1) : isize;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    sync_pend_d = sync_pend_q | sync;
    iacnt_d     = iacnt_q;
    ibcnt_d     = ibcnt_q;
    err_d       = err_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    beat_d      = beat_q;

    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    if (push && !pop)      level_d = level_q + (FIFO_AW+1)'(1);
    else if (!push && pop) level_d = level_q - (FIFO_AW+1)'(1);

    case (state_q)
      ST_IDLE: begin
        if (!sync_pend_q && (level_q >= BURST_LVL)) begin
          awaddr_d  = (ibase & ALIGN_MASK) + (32'(iacnt_q) << BB_LG);
          awvalid_d = 1'b1;
          state_d   = ST_AW;
        end
      end
      ST_AW: begin
        if (AXI_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          beat_d    = '0;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (pop) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            wvalid_d = 1'b0;
            bready_d = 1'b1;
            state_d  = ST_B;
          end
        end
      end
      ST_B: begin
        if (AXI_bvalid) begin
          bready_d = 1'b0;
          if ((AXI_bresp != 2'b00) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
          // ">=" rather than "==" so that a shrunken isize still wraps cleanly.
          if (iacnt_q >= isize_eff - SIZE_W'(1)) begin
            iacnt_d = '0;
            ibcnt_d = ibcnt_q + 32'd1;
          end else begin
            iacnt_d = iacnt_q + SIZE_W'(1);
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      iacnt_d     = '0;
      ibcnt_d     = '0;
      err_d       = '0;
      sync_pend_d = sync;
    end
  end

  always_ff @(posedge AXI_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      sync_pend_q <= 1'b0;
      iacnt_q     <= '0;
      ibcnt_q     <= '0;
      err_q       <= '0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      sync_pend_q <= sync_pend_d;
      iacnt_q     <= iacnt_d;
      ibcnt_q     <= ibcnt_d;
      err_q       <= err_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      beat_q      <= beat_d;
    end
  end

  // The storage array has no reset; its contents are visible only through wdata while wvalid is high.
  always_ff @(posedge AXI_clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  assign iacnt       = iacnt_q;
  assign ibcnt       = ibcnt_q;
  assign ierr_cnt    = err_q;
  assign AXI_awaddr  = awaddr_q;
  assign AXI_awlen   = 8'(BURST_LEN - 1);
  assign AXI_awsize  = 3'($clog2(DATA_W / 8));
  assign AXI_awburst = 2'b01;
  assign AXI_awvalid = awvalid_q;
  assign AXI_wdata   = wvalid_q ? mem_q[rd_ptr_q] : '0;
  assign AXI_wstrb   = '1;
  assign AXI_wvalid  = wvalid_q;
  assign AXI_wlast   = wvalid_q && (beat_q == LAST_BEAT);
  assign AXI_bready  = bready_q;

endmodule

// File: tb/tb_s2a_burst_writer.sv
module tb_s2a_burst_writer;
  localparam int DATA_W    = 64;
  localparam int BURST_LEN = 16;
  localparam int FIFO_AW   = 5;
  localparam int SIZE_W    = 18;

  logic              clk;
  logic              rst, sync;
  logic [DATA_W-1:0] s_data;
  logic              s_valid, s_ready;
  logic [31:0]       ibase;
  logic [SIZE_W-1:0] isize, iacnt;
  logic [31:0]       ibcnt;
  logic [15:0]       ierr_cnt;
  logic [31:0]       AXI_awaddr;
  logic [7:0]        AXI_awlen;
  logic [2:0]        AXI_awsize;
  logic [1:0]        AXI_awburst;
  logic              AXI_awvalid, AXI_awready;
  logic [DATA_W-1:0] AXI_wdata;
  logic [DATA_W/8-1:0] AXI_wstrb;
  logic              AXI_wvalid, AXI_wready, AXI_wlast;
  logic              AXI_bvalid, AXI_bready;
  logic [1:0]        AXI_bresp;

  s2a_burst_writer #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .FIFO_AW(FIFO_AW), .SIZE_W(SIZE_W)) dut (
    .AXI_clk(clk), .rst(rst), .sync(sync),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ibase(ibase), .isize(isize), .iacnt(iacnt), .ibcnt(ibcnt), .ierr_cnt(ierr_cnt),
    .AXI_awaddr(AXI_awaddr), .AXI_awlen(AXI_awlen), .AXI_awsize(AXI_awsize),
    .AXI_awburst(AXI_awburst), .AXI_awvalid(AXI_awvalid), .AXI_awready(AXI_awready),
    .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb), .AXI_wvalid(AXI_wvalid),
    .AXI_wready(AXI_wready), .AXI_wlast(AXI_wlast),
    .AXI_bvalid(AXI_bvalid), .AXI_bresp(AXI_bresp), .AXI_bready(AXI_bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // Scoreboard of accepted samples, plus a reference model of the burst index, wraps and errors.
  logic [63:0] exp_q [$];
  int m_idx = 0, m_bcnt = 0, m_err = 0;
  int bursts_done = 0, open_bursts = 0, mon_beat = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, err_at = -1;
  bit b_pend = 0, b_fired = 0, rnd_mode = 0, w_en = 1;
  logic [31:0] exp_addr;
  logic [63:0] exp_d;
  int eff;

  // AXI slave plus monitor. At each falling edge it sets the ready/valid signals for the next rising edge,
  // then scores the handshakes that edge will complete.
  initial begin : slave
    AXI_awready = 0; AXI_wready = 0; AXI_bvalid = 0; AXI_bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        AXI_awready = 0; AXI_wready = 0; AXI_bvalid = 0; AXI_bresp = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_pend = 0; b_fired = 0;
        open_bursts = 0; mon_beat = 0;
      end else begin
        // B channel
        if (b_fired) begin AXI_bvalid = 0; AXI_bresp = 2'b00; b_fired = 0; end
        if (b_pend && !AXI_bvalid) begin
          if (b_cnt == 0) begin
            AXI_bvalid = 1;
            AXI_bresp  = (bursts_done == err_at) ? 2'b10 : 2'b00;
          end else b_cnt--;
        end
        b_fired = AXI_bvalid && AXI_bready;
        if (b_fired) begin
          b_pend = 0;
          open_bursts--;
          bursts_done++;
          if (AXI_bresp != 2'b00) m_err++;
          eff = (isize == '0) ? 1 : int'(isize);
          if (m_idx >= eff - 1) begin m_idx = 0; m_bcnt++; end
          else m_idx++;
        end
        // AW channel
        if (AXI_awvalid && aw_cnt == 0) AXI_awready = 1;
        else begin
          AXI_awready = 0;
          if (AXI_awvalid) aw_cnt--;
        end
        if (AXI_awvalid && AXI_awready) begin
          aw_cnt = rnd_mode ? int'($urandom_range(0, 7)) : 0;
          exp_addr = (ibase & 32'hFFFF_FF80) + 32'(m_idx) * 32'd128;
          checks++;
          if (AXI_awaddr !== exp_addr) begin
            failures++;
            $display("FAIL aw_addr: got %h, expected %h", AXI_awaddr, exp_addr);
          end
          checks++;
          if (open_bursts != 0) begin
            failures++;
            $display("FAIL one_outstanding: AW with %0d bursts open, expected 0", open_bursts);
          end
          open_bursts++;
          mon_beat = 0;
        end
        // W channel
        if (AXI_wvalid && w_en && w_cnt == 0) AXI_wready = 1;
        else begin
          AXI_wready = 0;
          if (AXI_wvalid && w_en) w_cnt--;
        end
        if (AXI_wvalid && AXI_wready) begin
          w_cnt = rnd_mode ? int'($urandom_range(0, 7)) : 0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL w_data: got %h, expected no beat (scoreboard empty)", AXI_wdata);
          end else begin
            exp_d = exp_q.pop_front();
            if (AXI_wdata !== exp_d) begin
              failures++;
              $display("FAIL w_data: got %h, expected %h", AXI_wdata, exp_d);
            end
          end
          checks++;
          if (AXI_wlast !== (mon_beat == BURST_LEN - 1) || open_bursts != 1 || mon_beat >= BURST_LEN) begin
            failures++;
            $display("FAIL w_beat: beat %0d wlast=%b open=%0d, expected wlast only on beat %0d of one open burst",
                     mon_beat, AXI_wlast, open_bursts, BURST_LEN - 1);
          end
          mon_beat++;
          if (AXI_wlast) begin
            b_pend = 1;
            b_cnt  = rnd_mode ? int'($urandom_range(0, 7)) : 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  task automatic send_words(input int n, output int acc);
    int t;
    logic [63:0] d;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      t = 0;
      d = {$urandom, $urandom};
      @(negedge clk);
      s_valid = 1; s_data = d;
      while (!s_ready && t < 3000) begin @(negedge clk); t++; end
      if (s_ready) begin exp_q.push_back(d); acc++; end
      else break;
    end
    @(negedge clk);
    s_valid = 0;
  endtask

  task automatic wait_bursts(input int target, output int got);
    int t;
    t = 0;
    while (bursts_done < target && t < 5000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    got = bursts_done;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    m_idx = 0; m_bcnt = 0; m_err = 0;
    rst = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, AXI_awvalid, AXI_wvalid, AXI_bready, AXI_wlast} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: {s_ready,awvalid,wvalid,bready,wlast}=%b, expected 00000",
               {s_ready, AXI_awvalid, AXI_wvalid, AXI_bready, AXI_wlast});
    end
    checks++;
    if (iacnt !== '0 || ibcnt !== 32'd0 || ierr_cnt !== 16'd0 || AXI_awaddr !== 32'd0 || AXI_wdata !== '0) begin
      failures++;
      $display("FAIL reset_cnt: iacnt=%0d ibcnt=%0d ierr=%0d awaddr=%h wdata=%h, expected all 0",
               iacnt, ibcnt, ierr_cnt, AXI_awaddr, AXI_wdata);
    end
    checks++;
    if (AXI_awlen !== 8'd15 || AXI_awsize !== 3'd3 || AXI_awburst !== 2'b01 || AXI_wstrb !== 8'hFF) begin
      failures++;
      $display("FAIL consts: awlen=%0d awsize=%0d awburst=%b wstrb=%h, expected 15 3 01 ff",
               AXI_awlen, AXI_awsize, AXI_awburst, AXI_wstrb);
    end
    rst = 0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: s_ready=%b after reset, expected 1", s_ready);
    end
  endtask

  task automatic test_basic();
    int acc, got, target;
    rnd_mode = 0; w_en = 1; ibase = 32'h1000_0000; isize = 4;
    target = bursts_done + 4;
    send_words(64, acc);
    wait_bursts(target, got);
    checks++;
    if (acc !== 64 || got !== target || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL basic_flow: accepted=%0d bursts=%0d left=%0d, expected 64 %0d 0", acc, got, exp_q.size(), target);
    end
    checks++;
    if (iacnt !== '0 || ibcnt !== 32'd1) begin
      failures++;
      $display("FAIL basic_cnt: iacnt=%0d ibcnt=%0d, expected 0 1", iacnt, ibcnt);
    end
  endtask

  task automatic test_backpressure();
    int acc, got, target;
    rnd_mode = 1; w_en = 1;
    target = bursts_done + 6;
    send_words(96, acc);
    wait_bursts(target, got);
    checks++;
    if (acc !== 96 || got !== target || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL bp_flow: accepted=%0d bursts=%0d left=%0d, expected 96 %0d 0", acc, got, exp_q.size(), target);
    end
    checks++;
    if (iacnt !== SIZE_W'(m_idx) || ibcnt !== 32'(m_bcnt)) begin
      failures++;
      $display("FAIL bp_cnt: iacnt=%0d ibcnt=%0d, expected %0d %0d", iacnt, ibcnt, m_idx, m_bcnt);
    end
  endtask

  task automatic test_fifo_full();
    int acc, got, target, ready_seen;
    rnd_mode = 0; w_en = 0;
    target = bursts_done + 2;
    send_words(32, acc);
    checks++;
    if (acc !== 32) begin
      failures++;
      $display("FAIL fill_accept: accepted=%0d, expected 32", acc);
    end
    ready_seen = 0;
    @(negedge clk);
    s_valid = 1; s_data = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (8) begin
      if (s_ready) ready_seen++;
      @(negedge clk);
    end
    s_valid = 0;
    checks++;
    if (ready_seen !== 0) begin
      failures++;
      $display("FAIL full_ready: s_ready high %0d cycles when full, expected 0", ready_seen);
    end
    w_en = 1;
    wait_bursts(target, got);
    checks++;
    if (got !== target || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL full_drain: bursts=%0d left=%0d, expected %0d 0", got, exp_q.size(), target);
    end
  endtask

  task automatic test_bresp_err();
    int acc, got, target;
    rnd_mode = 0; w_en = 1;
    err_at = bursts_done + 1;
    target = bursts_done + 3;
    send_words(48, acc);
    wait_bursts(target, got);
    err_at = -1;
    checks++;
    if (acc !== 48 || got !== target) begin
      failures++;
      $display("FAIL err_flow: accepted=%0d bursts=%0d, expected 48 %0d", acc, got, target);
    end
    checks++;
    if (ierr_cnt !== 16'd1 || iacnt !== SIZE_W'(m_idx) || ibcnt !== 32'(m_bcnt)) begin
      failures++;
      $display("FAIL err_cnt: ierr=%0d iacnt=%0d ibcnt=%0d, expected 1 %0d %0d", ierr_cnt, iacnt, ibcnt, m_idx, m_bcnt);
    end
  endtask

  task automatic test_sync();
    int acc, got, target, t;
    rnd_mode = 1; w_en = 1;
    target = bursts_done + 1;
    send_words(20, acc);
    t = 0;
    while (!(open_bursts == 1 && mon_beat >= 4 && mon_beat < BURST_LEN && AXI_wvalid) && t < 2000) begin
      @(negedge clk); t++;
    end
    checks++;
    if (acc !== 20 || !AXI_wvalid) begin
      failures++;
      $display("FAIL sync_setup: accepted=%0d wvalid=%b, expected 20 1", acc, AXI_wvalid);
    end
    sync = 1;
    @(negedge clk);
    sync = 0;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL sync_ready: s_ready=%b while sync pending, expected 0", s_ready);
    end
    wait_bursts(target, got);
    checks++;
    if (got !== target || exp_q.size() !== 4) begin
      failures++;
      $display("FAIL sync_burst: bursts=%0d leftover=%0d, expected %0d 4", got, exp_q.size(), target);
    end
    exp_q.delete();
    m_idx = 0; m_bcnt = 0; m_err = 0;
    checks++;
    if (iacnt !== '0 || ibcnt !== 32'd0 || ierr_cnt !== 16'd0) begin
      failures++;
      $display("FAIL sync_clear: iacnt=%0d ibcnt=%0d ierr=%0d, expected 0 0 0", iacnt, ibcnt, ierr_cnt);
    end
    rnd_mode = 0;
    target = bursts_done + 1;
    send_words(16, acc);
    wait_bursts(target, got);
    checks++;
    if (got !== target || exp_q.size() !== 0 || iacnt !== SIZE_W'(m_idx)) begin
      failures++;
      $display("FAIL sync_after: bursts=%0d left=%0d iacnt=%0d, expected %0d 0 %0d", got, exp_q.size(), iacnt, target, m_idx);
    end
  endtask

  task automatic test_isize0_rst();
    int acc, got, target, t;
    do_reset();
    rnd_mode = 0; w_en = 1; isize = 0;
    target = bursts_done + 3;
    send_words(48, acc);
    wait_bursts(target, got);
    checks++;
    if (got !== target || iacnt !== '0 || ibcnt !== 32'(m_bcnt) || m_bcnt !== 3) begin
      failures++;
      $display("FAIL isize0: bursts=%0d iacnt=%0d ibcnt=%0d, expected %0d 0 3", got, iacnt, ibcnt, target);
    end
    w_en = 0;
    send_words(16, acc);
    t = 0;
    while (!AXI_wvalid && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (AXI_wvalid !== 1'b1) begin
      failures++;
      $display("FAIL rst_setup: wvalid=%b, expected 1", AXI_wvalid);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({s_ready, AXI_awvalid, AXI_wvalid, AXI_bready, AXI_wlast} !== 5'b0 || AXI_wdata !== '0 ||
        AXI_awaddr !== 32'd0 || ibcnt !== 32'd0 || iacnt !== '0 || ierr_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_midw: ctrl=%b wdata=%h awaddr=%h ibcnt=%0d, expected all 0",
               {s_ready, AXI_awvalid, AXI_wvalid, AXI_bready, AXI_wlast}, AXI_wdata, AXI_awaddr, ibcnt);
    end
    @(negedge clk);
    exp_q.delete();
    m_idx = 0; m_bcnt = 0; m_err = 0;
    rst = 0; w_en = 1; isize = 4;
    target = bursts_done + 1;
    send_words(16, acc);
    wait_bursts(target, got);
    checks++;
    if (got !== target || exp_q.size() !== 0 || iacnt !== SIZE_W'(1)) begin
      failures++;
      $display("FAIL rst_after: bursts=%0d left=%0d iacnt=%0d, expected %0d 0 1", got, exp_q.size(), iacnt, target);
    end
  endtask

  initial begin
    rst = 1; sync = 0; s_valid = 0; s_data = '0;
    ibase = 32'h1000_0000; isize = 4;
    test_reset();
    test_basic();
    test_backpressure();
    test_fifo_full();
    test_bresp_err();
    test_sync();
    test_isize0_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
